// File: rtl/sam_clk_div.sv
// Runtime-programmable sample-clock divider with rise/fall strobes and phase sync.
// Optional symbol strobe is built only when SAM_CLK_DIV_SYM_EN is defined.
module sam_clk_div #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 50,
  parameter int SYM_DIV     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_ratio_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             sym_en_o
);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  localparam int              DEF_CLAMP = (DIV_DEFAULT < 2) ? 2 : DIV_DEFAULT;
  localparam logic [CNT_W-1:0] DEF_EFF  = CNT_W'(DEF_CLAMP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] ratio_eff;
  logic [CNT_W-1:0] low_len, high_len;

  always_comb begin
    ratio_eff = (div_ratio_i < CNT_W'(2)) ? CNT_W'(2) : div_ratio_i;
    // Odd ratios put the extra cycle in the low phase.
    high_len  = active_q >> 1;
    low_len   = active_q - high_len;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    shadow_d = div_load_i ? ratio_eff : shadow_q;
    active_d = active_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_i) begin
      state_d  = ST_LOW;
      cnt_d    = '0;
      active_d = shadow_d;
    end else begin
      case (state_q)
        ST_LOW: begin
          if (cnt_q == low_len - CNT_W'(1)) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end
        end
        ST_HIGH: begin
          // Period boundary: a load on this same edge takes effect at once.
          if (cnt_q == high_len - CNT_W'(1)) begin
            state_d  = ST_LOW;
            cnt_d    = '0;
            fall_d   = 1'b1;
            active_d = shadow_d;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      shadow_q <= DEF_EFF;
      active_q <= DEF_EFF;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign clk_o  = (state_q == ST_HIGH);
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef SAM_CLK_DIV_SYM_EN
  localparam int SYM_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             sym_en_q, sym_en_d;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    sym_en_d  = 1'b0;
    if (sync_i) begin
      sym_cnt_d = '0;
    end else if (rise_d) begin
      if (sym_cnt_q == SYM_W'(SYM_DIV - 1)) begin
        sym_cnt_d = '0;
        sym_en_d  = 1'b1;
      end else begin
        sym_cnt_d = sym_cnt_q + SYM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
      sym_en_q  <= 1'b0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      sym_en_q  <= sym_en_d;
    end
  end

  assign sym_en_o = sym_en_q;
`else
  assign sym_en_o = 1'b0;
`endif

endmodule

// File: tb/tb_sam_clk_div.sv
// Self-checking bench for sam_clk_div: period-position reference model plus
// directed scenarios with literal edge numbers, then randomized load/sync/reset.
module tb_sam_clk_div;

  localparam int CNT_W       = 16;
  localparam int DIV_DEFAULT = 50;
  localparam int SYM_DIV     = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             div_load_i = 1'b0;
  logic [CNT_W-1:0] div_ratio_i = '0;
  logic             sync_i = 1'b0;
  logic             clk_o, rise_o, fall_o, sym_en_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  sam_clk_div #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT), .SYM_DIV(SYM_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .div_load_i(div_load_i), .div_ratio_i(div_ratio_i),
    .sync_i(sync_i), .clk_o(clk_o), .rise_o(rise_o), .fall_o(fall_o), .sym_en_o(sym_en_o)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: position k (1..N) of the last edge within the current period.
  int m_n = DIV_DEFAULT, m_sh = DIV_DEFAULT, m_k = 0, m_rises = 0;
  bit e_clk = 0, e_rise = 0, e_fall = 0, e_sym = 0;

  function automatic int clampr(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nsh, lo;
    if (!rst_n) begin
      m_sh = clampr(DIV_DEFAULT); m_n = clampr(DIV_DEFAULT);
      m_k = 0; m_rises = 0;
      e_clk = 0; e_rise = 0; e_fall = 0; e_sym = 0;
    end else begin
      nsh  = div_load_i ? clampr(int'(div_ratio_i)) : m_sh;
      m_sh = nsh;
      if (sync_i) begin
        m_k = 0; m_n = nsh; m_rises = 0;
        e_clk = 0; e_rise = 0; e_fall = 0; e_sym = 0;
      end else begin
        lo     = m_n - m_n / 2;
        m_k    = m_k + 1;
        e_rise = (m_k == lo);
        e_fall = (m_k == m_n);
        e_clk  = (m_k >= lo) && (m_k < m_n);
        e_sym  = 0;
        if (e_rise) begin
          m_rises = m_rises + 1;
`ifdef SAM_CLK_DIV_SYM_EN
          e_sym = (m_rises % SYM_DIV) == 0;
`endif
        end
        if (m_k == m_n) begin
          m_k = 0;
          m_n = nsh;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("clk_o",    int'(clk_o),    int'(e_clk));
    chk("rise_o",   int'(rise_o),   int'(e_rise));
    chk("fall_o",   int'(fall_o),   int'(e_fall));
    chk("sym_en_o", int'(sym_en_o), int'(e_sym));
  end

  // which: 0 = rise_o, 1 = fall_o, 2 = sym_en_o; returns the edge number it appeared after.
  task automatic wait_for(input int which, input int budget, input string nm, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && rise_o) || (which == 1 && fall_o) || (which == 2 && sym_en_o)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no strobe within %0d cycles, expected one", nm, budget);
    end
  endtask

  task automatic sync_load(input int r, output int s);
    @(negedge clk);
    sync_i = 1'b1; div_load_i = 1'b1; div_ratio_i = CNT_W'(r);
    @(negedge clk);
    s = cyc;
    sync_i = 1'b0; div_load_i = 1'b0;
  endtask

  initial begin
    int s, at, f, nsym;
    repeat (3) @(negedge clk);
    chk("reset_clk_o", int'(clk_o), 0);
    rst_n = 1'b1;
    s = cyc;

    // Default ratio 50
    wait_for(0, 100, "def_rise1", at);  chk("def_rise1", at - s, 25);
    wait_for(1, 100, "def_fall1", at);  chk("def_fall1", at - s, 50);
    wait_for(0, 100, "def_rise2", at);  chk("def_rise2", at - s, 75);

    // Odd ratio 5
    sync_load(5, s);
    wait_for(0, 20, "odd_rise1", at);   chk("odd_rise1", at - s, 3);
    wait_for(1, 20, "odd_fall1", at);   chk("odd_fall1", at - s, 5);
    wait_for(0, 20, "odd_rise2", at);   chk("odd_rise2", at - s, 8);

    // Mid-period load of 10 at edge 30 of a 50-cycle period
    sync_load(50, s);
    wait_for(0, 100, "mid_rise1", at);  chk("mid_rise1", at - s, 25);
    repeat (4) @(negedge clk);
    div_load_i = 1'b1; div_ratio_i = 16'd10;
    @(negedge clk);
    div_load_i = 1'b0;
    wait_for(1, 100, "mid_fall", at);   chk("mid_fall", at - s, 50);
    wait_for(0, 100, "mid_rise2", at);  chk("mid_rise2", at - s, 55);

    // Clamp 0 -> 2, then load 8 exactly on a boundary edge
    @(negedge clk);
    div_load_i = 1'b1; div_ratio_i = 16'd0;
    @(negedge clk);
    div_load_i = 1'b0;
    wait_for(1, 40, "clamp_fall", f);
    wait_for(0, 10, "clamp_rise", at);  chk("clamp_rise", at - f, 1);
    div_load_i = 1'b1; div_ratio_i = 16'd8;
    @(negedge clk);
    div_load_i = 1'b0;
    chk("boundary_fall", int'(fall_o), 1);
    wait_for(0, 20, "b8_rise", at);     chk("b8_rise", at - f, 6);
    wait_for(1, 20, "b8_fall", at);     chk("b8_fall", at - f, 10);

    // Sync cutting a high phase at edge 35
    sync_load(50, s);
    repeat (34) @(negedge clk);
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    chk("sync_cut_clk", int'(clk_o), 0);
    chk("sync_cut_fall", int'(fall_o), 0);
    f = cyc;
    wait_for(0, 100, "sync_rise", at);  chk("sync_rise", at - f, 25);

    // Symbol strobe
    sync_load(50, s);
`ifdef SAM_CLK_DIV_SYM_EN
    wait_for(2, 400, "sym1", at);       chk("sym1", at - s, 175);
    wait_for(2, 400, "sym2", at);       chk("sym2", at - s, 375);
`else
    nsym = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sym_en_o) nsym++;
    end
    chk("sym_count", nsym, 0);
`endif

    // Randomized load / sync / mid-period reset against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      div_load_i  = ($urandom_range(0, 19) == 0);
      div_ratio_i = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 40))
                                                : CNT_W'($urandom_range(0, 12));
      sync_i      = ($urandom_range(0, 59) == 0) ? 1'b1 : (sync_i && $urandom_range(0, 1) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        div_load_i = 1'b0; sync_i = 1'b0;
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    div_load_i = 1'b0; sync_i = 1'b0;
    repeat (120) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
